// File: rtl/regfile_dump_pkg.sv
// Shared constants and FSM state type for the register-file dump engine.
// The register file and the dump block both size themselves from these values.
package regfile_dump_pkg;

    localparam int NUM_REGS = 32;
    localparam int XLEN     = 32;
    localparam int AW       = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready beat stream carrying one register (index + value) per beat.
interface regfile_dump_if #(
    parameter int XLEN = regfile_dump_pkg::XLEN,
    parameter int AW   = regfile_dump_pkg::AW
);

    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_idx;
    logic [XLEN-1:0] out_data;
    logic            out_last;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_dump.sv
// Walks every architectural register through a spare combinational read port
// and streams {index, value} beats out over a valid/ready interface.
module regfile_dump #(
    parameter int NUM_REGS = regfile_dump_pkg::NUM_REGS,
    parameter int XLEN     = regfile_dump_pkg::XLEN,
    parameter int AW       = regfile_dump_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [AW-1:0]        rf_addr,
    input  logic [XLEN-1:0]      rf_data,
    regfile_dump_if.master       dump,
    output logic                 busy,
    output logic                 done
);

    import regfile_dump_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    state_e          state;
    logic [AW-1:0]   idx;
    logic            out_valid_q;
    logic            out_last_q;
    logic [AW-1:0]   out_idx_q;
    logic [XLEN-1:0] out_data_q;
    logic            accept;

    assign accept  = out_valid_q && dump.out_ready;
    assign rf_addr = idx;

    assign dump.out_valid = out_valid_q;
    assign dump.out_last  = out_last_q;
    assign dump.out_idx   = out_idx_q;
    assign dump.out_data  = out_data_q;

    assign busy = (state == ST_RUN) || (state == ST_LAST);
    assign done = (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the output data register is reset as well so
    // a mid-dump reset leaves every visible output at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (!out_valid_q || accept) begin
                        // Capture happens at the edge, so a register written
                        // before this edge is reported with its new value.
                        out_idx_q   <= idx;
                        out_data_q  <= rf_data;
                        out_valid_q <= 1'b1;
                        if (idx == LAST_IDX) begin
                            out_last_q <= 1'b1;
                            state      <= ST_LAST;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                ST_LAST: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (accept) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a behavioural register file plus a
// beat-order model driven through directed and randomized back-pressure runs.
module tb_regfile_dump;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        busy;
    logic        done;

    logic [31:0] rf_mem  [NR];
    logic [31:0] ref_reg [NR];

    int n_pass  = 0;
    int n_total = 0;

    regfile_dump_if #(.XLEN(32), .AW(5)) dump_if ();

    regfile_dump #(.NUM_REGS(NR), .XLEN(32), .AW(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .dump    (dump_if),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    assign rf_data = (rf_addr == 5'd0) ? 32'd0 : rf_mem[rf_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic rf_write(input int n, input logic [31:0] val);
        rf_mem[n]  = val;
        ref_reg[n] = val;
    endtask

    function automatic logic [31:0] expect_val(input int n);
        return (n == 0) ? 32'd0 : ref_reg[n];
    endfunction

    // Caller must be positioned just after a falling edge.
    // mode 0: ready always 1; 1: random ready; 2: stall 5 cycles on beat 3.
    task automatic run_dump(input int mode, input bit glitch, input bit wr7, input string tag);
        int  nexp = 0;
        int  stall = 0;
        int  dones = 0;
        bit  pend = 0;
        bit  fin = 0;
        bit  wrote = 0;
        logic r;
        start = 1'b1;
        dump_if.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_valid_not_yet"}, dump_if.out_valid, 0);
        @(negedge clk);
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (cyc == 0) check({tag, "_first_beat_latency"}, dump_if.out_valid, 1);
            if (dump_if.out_valid) begin
                check({tag, "_idx"}, dump_if.out_idx, nexp);
                check({tag, "_data"}, dump_if.out_data, expect_val(nexp));
                check({tag, "_last"}, dump_if.out_last, (nexp == NR - 1));
            end
            case (mode)
                1: r = ($urandom_range(0, 3) != 0);
                2: begin
                    if (dump_if.out_valid && dump_if.out_idx == 5'd3 && stall < 5) begin
                        r = 1'b0;
                        stall++;
                    end else r = 1'b1;
                end
                default: r = 1'b1;
            endcase
            dump_if.out_ready = r;
            start = glitch && (nexp == 12);
            if (wr7 && !wrote && dump_if.out_valid && dump_if.out_idx == 5'd5) begin
                rf_write(7, 32'hDEAD_BEEF);
                wrote = 1;
            end
            if (dump_if.out_valid && r) begin
                if (wr7 && nexp == 7) check({tag, "_beat7_new_value"}, dump_if.out_data, 32'hDEAD_BEEF);
                nexp++;
                if (nexp == NR) pend = 1;
            end
            @(negedge clk);
            if (done) dones++;
            if (pend) begin
                check({tag, "_done_after_last"}, done, 1);
                check({tag, "_valid_cleared"}, dump_if.out_valid, 0);
                fin = 1;
            end
        end
        start = 1'b0;
        dump_if.out_ready = 1'b1;
        check({tag, "_beat_count"}, nexp, NR);
        if (mode == 2) check({tag, "_stall_cycles"}, stall, 5);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_idle_after"}, busy, 0);
        check({tag, "_done_pulses"}, dones, 1);
    endtask

    task automatic wait_idx(input int k, input string tag);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (dump_if.out_valid && dump_if.out_idx == k[4:0]) ok = 1;
        end
        check({tag, "_reach_idx"}, ok, 1);
    endtask

    initial begin
        dump_if.out_ready = 1'b1;
        for (int n = 0; n < NR; n++) rf_write(n, 32'h1000_0000 + n);

        // Reset state.
        #3;
        check("rst_valid", dump_if.out_valid, 0);
        check("rst_last", dump_if.out_last, 0);
        check("rst_idx", dump_if.out_idx, 0);
        check("rst_data", dump_if.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rf_addr", rf_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_dump(0, 0, 0, "full");
        @(negedge clk);
        run_dump(2, 0, 0, "stall");
        @(negedge clk);
        run_dump(0, 0, 1, "wr7");
        @(negedge clk);
        run_dump(1, 0, 0, "rand_a");
        @(negedge clk);
        for (int n = 1; n < NR; n++) rf_write(n, $urandom);
        run_dump(1, 0, 0, "rand_b");

        // Abort while beat 10 is valid.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idx(10, "abort");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", dump_if.out_valid, 0);
        check("abort_last", dump_if.out_last, 0);
        check("abort_busy", busy, 0);
        begin
            int dn = 0;
            for (int i = 0; i < 6; i++) begin
                if (done) dn++;
                @(negedge clk);
            end
            check("abort_no_done", dn, 0);
        end
        run_dump(0, 0, 0, "after_abort");

        // start together with abort in IDLE is ignored.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        @(negedge clk);
        check("start_abort_valid", dump_if.out_valid, 0);

        // start pulsed while busy is ignored.
        run_dump(0, 1, 0, "glitch");

        // Asynchronous reset mid-dump at beat 20.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idx(20, "mid_rst");
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", dump_if.out_valid, 0);
        check("mid_rst_last", dump_if.out_last, 0);
        check("mid_rst_idx", dump_if.out_idx, 0);
        check("mid_rst_data", dump_if.out_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rf_addr", rf_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_dump(0, 0, 0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
